// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, controller state encoding and
// the read/write grant type used by the SRAM controller arbiter.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WR_ISSUE,
    WR_RESP,
    RD_ISSUE,
    RD_CAPT,
    RD_RESP
  } ctrl_state_e;

  typedef enum logic {
    READ,
    WRITE
  } grant_e;

endpackage

// File: rtl/axi_lite_sram_ctrl.sv
// AXI4-Lite slave driving a single-port SRAM macro (1-cycle registered read).
// One transaction in flight; reads and writes alternate fairly on contention.
module axi_lite_sram_ctrl
  import axi_lite_pkg::*;
#(
  parameter int SRAM_AW   = 8,
  parameter int MEM_WORDS = 64,
  parameter int AXI_AW    = SRAM_AW + 2
) (
  input  logic               clk,
  input  logic               rst_i,

  input  logic [AXI_AW-1:0]  s_awaddr_i,
  input  logic               s_awvalid_i,
  output logic               s_awready_o,
  input  logic [31:0]        s_wdata_i,
  input  logic [3:0]         s_wstrb_i,
  input  logic               s_wvalid_i,
  output logic               s_wready_o,
  output logic [1:0]         s_bresp_o,
  output logic               s_bvalid_o,
  input  logic               s_bready_i,

  input  logic [AXI_AW-1:0]  s_araddr_i,
  input  logic               s_arvalid_i,
  output logic               s_arready_o,
  output logic [31:0]        s_rdata_o,
  output logic [1:0]         s_rresp_o,
  output logic               s_rvalid_o,
  input  logic               s_rready_i,

  output logic               sram_en_o,
  output logic [SRAM_AW-1:0] sram_addr_o,
  output logic [31:0]        sram_wdata_o,
  output logic               sram_we_o,
  output logic [3:0]         sram_be_o,
  input  logic [31:0]        sram_rdata_i
);

  // One extra bit so MEM_WORDS == 2**SRAM_AW is representable.
  localparam logic [SRAM_AW:0] MEM_WORDS_W = (SRAM_AW + 1)'(MEM_WORDS);

  ctrl_state_e        state_q,      state_d;
  grant_e             last_grant_q, last_grant_d;
  logic               err_q,        err_d;
  logic               bvalid_q,     bvalid_d;
  logic [1:0]         bresp_q,      bresp_d;
  logic               rvalid_q,     rvalid_d;
  logic [1:0]         rresp_q,      rresp_d;
  logic [31:0]        rdata_q,      rdata_d;
  logic               sram_en_q,    sram_en_d;
  logic               sram_we_q,    sram_we_d;
  logic [SRAM_AW-1:0] sram_addr_q,  sram_addr_d;
  logic [31:0]        sram_wdata_q, sram_wdata_d;
  logic [3:0]         sram_be_q,    sram_be_d;

  logic               idle;
  logic               wr_req;
  logic               grant_wr;
  logic               grant_rd;
  logic [SRAM_AW-1:0] aw_word;
  logic [SRAM_AW-1:0] ar_word;
  logic               aw_in_range;
  logic               ar_in_range;
  logic               unused_addr_lsbs;

  assign aw_word          = s_awaddr_i[AXI_AW-1:2];
  assign ar_word          = s_araddr_i[AXI_AW-1:2];
  assign aw_in_range      = {1'b0, aw_word} < MEM_WORDS_W;
  assign ar_in_range      = {1'b0, ar_word} < MEM_WORDS_W;
  assign unused_addr_lsbs = ^{s_awaddr_i[1:0], s_araddr_i[1:0]};

  // Readies are combinational so the grant and the handshake share a cycle;
  // gating with rst_i keeps them low while reset is held.
  assign idle     = (state_q == IDLE) && !rst_i;
  assign wr_req   = s_awvalid_i && s_wvalid_i;
  assign grant_wr = idle && wr_req && (!s_arvalid_i || last_grant_q == READ);
  assign grant_rd = idle && s_arvalid_i && (!wr_req || last_grant_q == WRITE);

  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    state_d      = state_q;
    last_grant_d = last_grant_q;
    err_d        = err_q;
    bvalid_d     = bvalid_q;
    bresp_d      = bresp_q;
    rvalid_d     = rvalid_q;
    rresp_d      = rresp_q;
    rdata_d      = rdata_q;
    sram_en_d    = 1'b0;
    sram_we_d    = 1'b0;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    sram_be_d    = sram_be_q;

    unique case (state_q)
      IDLE: begin
        if (grant_wr) begin
          state_d = WR_ISSUE;
          err_d   = !aw_in_range;
          if (s_arvalid_i) last_grant_d = WRITE;
          if (aw_in_range) begin
            sram_en_d    = 1'b1;
            sram_we_d    = 1'b1;
            sram_addr_d  = aw_word;
            sram_wdata_d = s_wdata_i;
            sram_be_d    = s_wstrb_i;
          end
        end else if (grant_rd) begin
          state_d = RD_ISSUE;
          err_d   = !ar_in_range;
          if (wr_req) last_grant_d = READ;
          if (ar_in_range) begin
            sram_en_d   = 1'b1;
            sram_addr_d = ar_word;
            sram_be_d   = 4'h0;
          end
        end
      end
      WR_ISSUE: begin
        state_d  = WR_RESP;
        bvalid_d = 1'b1;
        bresp_d  = err_q ? RESP_SLVERR : RESP_OKAY;
      end
      WR_RESP: begin
        if (s_bready_i) begin
          state_d  = IDLE;
          bvalid_d = 1'b0;
          bresp_d  = RESP_OKAY;
        end
      end
      RD_ISSUE: begin
        state_d = RD_CAPT;
      end
      RD_CAPT: begin
        state_d  = RD_RESP;
        rvalid_d = 1'b1;
        rdata_d  = err_q ? 32'h0 : sram_rdata_i;
        rresp_d  = err_q ? RESP_SLVERR : RESP_OKAY;
      end
      RD_RESP: begin
        if (s_rready_i) begin
          state_d  = IDLE;
          rvalid_d = 1'b0;
          rresp_d  = RESP_OKAY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      last_grant_q <= READ;
      err_q        <= 1'b0;
      bvalid_q     <= 1'b0;
      bresp_q      <= RESP_OKAY;
      rvalid_q     <= 1'b0;
      rresp_q      <= RESP_OKAY;
      rdata_q      <= 32'h0;
      sram_en_q    <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= 32'h0;
      sram_be_q    <= 4'h0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values,
      // independent of statement order.
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
      bvalid_q     <= bvalid_d;
      bresp_q      <= bresp_d;
      rvalid_q     <= rvalid_d;
      rresp_q      <= rresp_d;
      rdata_q      <= rdata_d;
      sram_en_q    <= sram_en_d;
      sram_we_q    <= sram_we_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      sram_be_q    <= sram_be_d;
    end
  end

  assign s_awready_o  = grant_wr;
  assign s_wready_o   = grant_wr;
  assign s_arready_o  = grant_rd;
  assign s_bvalid_o   = bvalid_q;
  assign s_bresp_o    = bresp_q;
  assign s_rvalid_o   = rvalid_q;
  assign s_rresp_o    = rresp_q;
  assign s_rdata_o    = rdata_q;
  assign sram_en_o    = sram_en_q;
  assign sram_we_o    = sram_we_q;
  assign sram_addr_o  = sram_addr_q;
  assign sram_wdata_o = sram_wdata_q;
  assign sram_be_o    = sram_be_q;

endmodule

// File: tb/tb_axi_lite_sram_ctrl.sv
// Directed bench for axi_lite_sram_ctrl with a behavioural sp_ram attached.
// Inputs change on the falling edge; outputs are sampled there as well.
module tb_axi_lite_sram_ctrl;

  localparam int SRAM_AW = 8;
  localparam int AXI_AW  = SRAM_AW + 2;

  logic               clk = 1'b0;
  logic               rst_i;
  logic [AXI_AW-1:0]  s_awaddr_i;
  logic               s_awvalid_i;
  logic               s_awready_o;
  logic [31:0]        s_wdata_i;
  logic [3:0]         s_wstrb_i;
  logic               s_wvalid_i;
  logic               s_wready_o;
  logic [1:0]         s_bresp_o;
  logic               s_bvalid_o;
  logic               s_bready_i;
  logic [AXI_AW-1:0]  s_araddr_i;
  logic               s_arvalid_i;
  logic               s_arready_o;
  logic [31:0]        s_rdata_o;
  logic [1:0]         s_rresp_o;
  logic               s_rvalid_o;
  logic               s_rready_i;
  logic               sram_en_o;
  logic [SRAM_AW-1:0] sram_addr_o;
  logic [31:0]        sram_wdata_o;
  logic               sram_we_o;
  logic [3:0]         sram_be_o;
  logic [31:0]        sram_rdata_i;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  axi_lite_sram_ctrl #(.SRAM_AW(SRAM_AW), .MEM_WORDS(64), .AXI_AW(AXI_AW)) dut (
    .clk          (clk),
    .rst_i        (rst_i),
    .s_awaddr_i   (s_awaddr_i),
    .s_awvalid_i  (s_awvalid_i),
    .s_awready_o  (s_awready_o),
    .s_wdata_i    (s_wdata_i),
    .s_wstrb_i    (s_wstrb_i),
    .s_wvalid_i   (s_wvalid_i),
    .s_wready_o   (s_wready_o),
    .s_bresp_o    (s_bresp_o),
    .s_bvalid_o   (s_bvalid_o),
    .s_bready_i   (s_bready_i),
    .s_araddr_i   (s_araddr_i),
    .s_arvalid_i  (s_arvalid_i),
    .s_arready_o  (s_arready_o),
    .s_rdata_o    (s_rdata_o),
    .s_rresp_o    (s_rresp_o),
    .s_rvalid_o   (s_rvalid_o),
    .s_rready_i   (s_rready_i),
    .sram_en_o    (sram_en_o),
    .sram_addr_o  (sram_addr_o),
    .sram_wdata_o (sram_wdata_o),
    .sram_we_o    (sram_we_o),
    .sram_be_o    (sram_be_o),
    .sram_rdata_i (sram_rdata_i)
  );

  // NOTE: the RAM array is deliberately not reset; real macros power up with
  // arbitrary contents, so it is only cleared once at time zero here.
  logic [31:0] mem [0:(1<<SRAM_AW)-1];
  initial begin
    for (int i = 0; i < (1 << SRAM_AW); i++) mem[i] = 32'h0;
    sram_rdata_i = 32'h0;
  end

  always @(posedge clk) begin
    if (sram_en_o) begin
      if (sram_we_o) begin
        for (int b = 0; b < 4; b++)
          if (sram_be_o[b]) mem[sram_addr_o][8*b +: 8] <= sram_wdata_o[8*b +: 8];
      end else begin
        sram_rdata_i <= mem[sram_addr_o];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic axi_write(input logic [AXI_AW-1:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic exp_en,
                           input logic [SRAM_AW-1:0] exp_addr, input logic [1:0] exp_resp);
    @(negedge clk);
    s_awaddr_i = addr; s_wdata_i = data; s_wstrb_i = strb;
    s_awvalid_i = 1'b1; s_wvalid_i = 1'b1; s_bready_i = 1'b1;
    #1;
    check("wr_awready", 32'(s_awready_o), 32'd1);
    check("wr_wready",  32'(s_wready_o),  32'd1);
    check("wr_arready", 32'(s_arready_o), 32'd0);
    @(negedge clk);
    s_awvalid_i = 1'b0; s_wvalid_i = 1'b0;
    check("wr_t1_en",     32'(sram_en_o),   32'(exp_en));
    check("wr_t1_we",     32'(sram_we_o),   32'(exp_en));
    check("wr_t1_addr",   32'(sram_addr_o), 32'(exp_addr));
    check("wr_t1_bvalid", 32'(s_bvalid_o),  32'd0);
    if (exp_en) begin
      check("wr_t1_be",    32'(sram_be_o), 32'(strb));
      check("wr_t1_wdata", sram_wdata_o,   data);
    end
    @(negedge clk);
    check("wr_t2_bvalid", 32'(s_bvalid_o), 32'd1);
    check("wr_t2_bresp",  32'(s_bresp_o),  32'(exp_resp));
    check("wr_t2_en",     32'(sram_en_o),  32'd0);
    @(negedge clk);
    check("wr_t3_bvalid", 32'(s_bvalid_o), 32'd0);
  endtask

  task automatic axi_read(input logic [AXI_AW-1:0] addr, input logic exp_en,
                          input logic [SRAM_AW-1:0] exp_addr, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp);
    @(negedge clk);
    s_araddr_i = addr; s_arvalid_i = 1'b1; s_rready_i = 1'b1;
    #1;
    check("rd_arready", 32'(s_arready_o), 32'd1);
    check("rd_awready", 32'(s_awready_o), 32'd0);
    @(negedge clk);
    s_arvalid_i = 1'b0;
    check("rd_t1_en",     32'(sram_en_o),   32'(exp_en));
    check("rd_t1_we",     32'(sram_we_o),   32'd0);
    check("rd_t1_addr",   32'(sram_addr_o), 32'(exp_addr));
    check("rd_t1_rvalid", 32'(s_rvalid_o),  32'd0);
    if (exp_en) check("rd_t1_be", 32'(sram_be_o), 32'd0);
    @(negedge clk);
    check("rd_t2_rvalid", 32'(s_rvalid_o), 32'd0);
    check("rd_t2_en",     32'(sram_en_o),  32'd0);
    @(negedge clk);
    check("rd_t3_rvalid", 32'(s_rvalid_o), 32'd1);
    check("rd_t3_rdata",  s_rdata_o,       exp_data);
    check("rd_t3_rresp",  32'(s_rresp_o),  32'(exp_resp));
    @(negedge clk);
    check("rd_t4_rvalid", 32'(s_rvalid_o), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_awready"}, 32'(s_awready_o), 32'd0);
    check({tag, "_wready"},  32'(s_wready_o),  32'd0);
    check({tag, "_arready"}, 32'(s_arready_o), 32'd0);
    check({tag, "_bvalid"},  32'(s_bvalid_o),  32'd0);
    check({tag, "_bresp"},   32'(s_bresp_o),   32'd0);
    check({tag, "_rvalid"},  32'(s_rvalid_o),  32'd0);
    check({tag, "_rresp"},   32'(s_rresp_o),   32'd0);
    check({tag, "_rdata"},   s_rdata_o,        32'd0);
    check({tag, "_en"},      32'(sram_en_o),   32'd0);
    check({tag, "_we"},      32'(sram_we_o),   32'd0);
    check({tag, "_addr"},    32'(sram_addr_o), 32'd0);
    check({tag, "_wdata"},   sram_wdata_o,     32'd0);
    check({tag, "_be"},      32'(sram_be_o),   32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rvalid_seen;
    rst_i = 1'b1;
    s_awaddr_i = '0; s_awvalid_i = 1'b0; s_wdata_i = 32'h0; s_wstrb_i = 4'h0;
    s_wvalid_i = 1'b0; s_bready_i = 1'b0; s_araddr_i = '0; s_arvalid_i = 1'b0;
    s_rready_i = 1'b0;
    #1;
    check_all_zero("rst");
    s_awvalid_i = 1'b1; s_wvalid_i = 1'b1; s_arvalid_i = 1'b1;
    #1;
    check("rst_awready_gated", 32'(s_awready_o), 32'd0);
    check("rst_arready_gated", 32'(s_arready_o), 32'd0);
    s_awvalid_i = 1'b0; s_wvalid_i = 1'b0; s_arvalid_i = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_i = 1'b0;

    // Full write then read, partial strobe, zero strobe.
    axi_write(10'h010, 32'hDEADBEEF, 4'hF, 1'b1, 8'd4, 2'b00);
    axi_read (10'h010, 1'b1, 8'd4, 32'hDEADBEEF, 2'b00);
    axi_write(10'h010, 32'h0000AA00, 4'h2, 1'b1, 8'd4, 2'b00);
    axi_read (10'h010, 1'b1, 8'd4, 32'hDEADAAEF, 2'b00);
    axi_write(10'h010, 32'hFFFFFFFF, 4'h0, 1'b1, 8'd4, 2'b00);
    axi_read (10'h010, 1'b1, 8'd4, 32'hDEADAAEF, 2'b00);

    // Asynchronous reset in the middle of a read (at T2).
    @(negedge clk);
    s_araddr_i = 10'h010; s_arvalid_i = 1'b1; s_rready_i = 1'b1;
    @(negedge clk);
    s_arvalid_i = 1'b0;
    @(negedge clk);
    check("rstrd_t2_rvalid", 32'(s_rvalid_o), 32'd0);
    check("rstrd_pre_rdata", s_rdata_o, 32'hDEADAAEF);
    #2 rst_i = 1'b1;
    #1;
    check_all_zero("rstrd");
    @(negedge clk);
    rst_i = 1'b0;
    rvalid_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (s_rvalid_o) rvalid_seen++;
    end
    check("rstrd_no_rvalid", 32'(rvalid_seen), 32'd0);
    axi_read(10'h010, 1'b1, 8'd4, 32'hDEADAAEF, 2'b00);

    // Out-of-range word 64: no SRAM access, address register holds.
    axi_write(10'h100, 32'h11111111, 4'hF, 1'b0, 8'd4, 2'b10);
    axi_read (10'h100, 1'b0, 8'd4, 32'h0, 2'b10);

    // Arbitration: first contention after reset goes to the write.
    @(negedge clk);
    s_awaddr_i = 10'h020; s_wdata_i = 32'h12345678; s_wstrb_i = 4'hF;
    s_awvalid_i = 1'b1; s_wvalid_i = 1'b1; s_bready_i = 1'b1;
    s_araddr_i = 10'h010; s_arvalid_i = 1'b1; s_rready_i = 1'b1;
    #1;
    check("arb1_awready", 32'(s_awready_o), 32'd1);
    check("arb1_wready",  32'(s_wready_o),  32'd1);
    check("arb1_arready", 32'(s_arready_o), 32'd0);
    @(negedge clk);
    s_awvalid_i = 1'b0; s_wvalid_i = 1'b0;
    check("arb1_t1_we",      32'(sram_we_o),   32'd1);
    check("arb1_t1_addr",    32'(sram_addr_o), 32'd8);
    check("arb1_t1_arready", 32'(s_arready_o), 32'd0);
    @(negedge clk);
    check("arb1_t2_bvalid",  32'(s_bvalid_o),  32'd1);
    check("arb1_t2_arready", 32'(s_arready_o), 32'd0);
    @(negedge clk);
    check("arb1_t3_arready", 32'(s_arready_o), 32'd1);
    check("arb1_t3_bvalid",  32'(s_bvalid_o),  32'd0);
    @(negedge clk);
    s_arvalid_i = 1'b0;
    check("arb1_rd_en",   32'(sram_en_o),   32'd1);
    check("arb1_rd_we",   32'(sram_we_o),   32'd0);
    check("arb1_rd_addr", 32'(sram_addr_o), 32'd4);
    @(negedge clk); @(negedge clk);
    check("arb1_rvalid", 32'(s_rvalid_o), 32'd1);
    check("arb1_rdata",  s_rdata_o,       32'hDEADAAEF);
    @(negedge clk);
    check("arb1_rvalid_done", 32'(s_rvalid_o), 32'd0);

    // Second contention: the read now wins.
    @(negedge clk);
    s_awaddr_i = 10'h020; s_wdata_i = 32'hCAFEF00D; s_wstrb_i = 4'hF;
    s_awvalid_i = 1'b1; s_wvalid_i = 1'b1;
    s_araddr_i = 10'h020; s_arvalid_i = 1'b1;
    #1;
    check("arb2_arready", 32'(s_arready_o), 32'd1);
    check("arb2_awready", 32'(s_awready_o), 32'd0);
    check("arb2_wready",  32'(s_wready_o),  32'd0);
    @(negedge clk);
    s_arvalid_i = 1'b0;
    check("arb2_rd_en",    32'(sram_en_o),   32'd1);
    check("arb2_rd_we",    32'(sram_we_o),   32'd0);
    check("arb2_rd_addr",  32'(sram_addr_o), 32'd8);
    check("arb2_t1_awrdy", 32'(s_awready_o), 32'd0);
    @(negedge clk); @(negedge clk);
    check("arb2_rvalid", 32'(s_rvalid_o), 32'd1);
    check("arb2_rdata",  s_rdata_o,       32'h12345678);
    @(negedge clk);
    check("arb2_awready_next", 32'(s_awready_o), 32'd1);
    @(negedge clk);
    s_awvalid_i = 1'b0; s_wvalid_i = 1'b0;
    check("arb2_wr_we",    32'(sram_we_o),    32'd1);
    check("arb2_wr_wdata", sram_wdata_o,      32'hCAFEF00D);
    @(negedge clk);
    check("arb2_bvalid", 32'(s_bvalid_o), 32'd1);
    check("arb2_bresp",  32'(s_bresp_o),  32'd0);
    @(negedge clk);

    // B backpressure with a read waiting, then R backpressure.
    s_awaddr_i = 10'h030; s_wdata_i = 32'h00000055; s_wstrb_i = 4'hF;
    s_awvalid_i = 1'b1; s_wvalid_i = 1'b1; s_bready_i = 1'b0;
    s_araddr_i = 10'h030; s_arvalid_i = 1'b1; s_rready_i = 1'b0;
    #1;
    check("bp_awready", 32'(s_awready_o), 32'd1);
    check("bp_arready", 32'(s_arready_o), 32'd0);
    @(negedge clk);
    s_awvalid_i = 1'b0; s_wvalid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_bvalid_hold",  32'(s_bvalid_o),  32'd1);
      check("bp_bresp_hold",   32'(s_bresp_o),   32'd0);
      check("bp_arready_hold", 32'(s_arready_o), 32'd0);
    end
    @(negedge clk);
    s_bready_i = 1'b1;
    #1;
    check("bp_bvalid_at_hs", 32'(s_bvalid_o), 32'd1);
    @(negedge clk);
    s_bready_i = 1'b0;
    check("bp_bvalid_after", 32'(s_bvalid_o),  32'd0);
    check("bp_arready_next", 32'(s_arready_o), 32'd1);
    @(negedge clk);
    s_arvalid_i = 1'b0;
    check("bp_rd_en",   32'(sram_en_o),   32'd1);
    check("bp_rd_addr", 32'(sram_addr_o), 32'd12);
    @(negedge clk); @(negedge clk);
    s_awaddr_i = 10'h034; s_awvalid_i = 1'b1; s_wvalid_i = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      check("rbp_rvalid_hold",  32'(s_rvalid_o),  32'd1);
      check("rbp_rdata_hold",   s_rdata_o,        32'h00000055);
      check("rbp_rresp_hold",   32'(s_rresp_o),   32'd0);
      check("rbp_awready_hold", 32'(s_awready_o), 32'd0);
      @(negedge clk);
    end
    s_awvalid_i = 1'b0; s_wvalid_i = 1'b0; s_rready_i = 1'b1;
    #1;
    check("rbp_rvalid_at_hs", 32'(s_rvalid_o), 32'd1);
    @(negedge clk);
    check("rbp_rvalid_after", 32'(s_rvalid_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
